// File: rtl/mips_defs.sv
// Shared MIPS datapath definitions: default word width, data-word reset value
// and the signed-overflow helper used by the adder.
package mips_defs;

    localparam int          WIDTH_DEFAULT = 32;
    localparam logic [31:0] DATA_RESET    = 32'h0;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder32_if.sv
// Operand/result bundle between the datapath (master) and the adder (slave).
interface adder32_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic [WIDTH-1:0] i_op1;
    logic [WIDTH-1:0] i_op2;
    logic [WIDTH-1:0] o_result;
    logic             o_valid;
    logic             o_carry;
    logic             o_overflow;

    modport master (
        output i_valid, i_op1, i_op2,
        input  o_result, o_valid, o_carry, o_overflow
    );

    modport slave (
        input  i_valid, i_op1, i_op2,
        output o_result, o_valid, o_carry, o_overflow
    );
endinterface

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead slice: internal carries in two gate levels, plus
// group generate/propagate for the next lookahead level.
module adder_cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_g,
    output logic       o_p,
    output logic       o_cout
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_g    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_p    = &w_p;
    assign o_cout = o_g | (o_p & i_cin);
    assign o_sum  = w_p ^ w_c;
endmodule

// File: rtl/adder32.sv
// Registered WIDTH-bit adder built from 4-bit CLA slices with a group-level
// carry chain. Define ADDER_FLAGS_EN to compute carry/overflow flags.
module adder32
    import mips_defs::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic      i_clk,
    input  logic      i_rst,
    adder32_if.slave  bus
);
    localparam int NSLICE = WIDTH / 4;

    logic [NSLICE:0]   w_carry;
    logic [NSLICE-1:0] w_g;
    logic [NSLICE-1:0] w_p;
    logic [NSLICE-1:0] w_cout;
    logic [WIDTH-1:0]  w_sum;

    logic [WIDTH-1:0]  r_result;
    logic              r_valid;

    assign w_carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            adder_cla4 u_cla4 (
                .i_a    (bus.i_op1[gi*4 +: 4]),
                .i_b    (bus.i_op2[gi*4 +: 4]),
                .i_cin  (w_carry[gi]),
                .o_sum  (w_sum[gi*4 +: 4]),
                .o_g    (w_g[gi]),
                .o_p    (w_p[gi]),
                .o_cout (w_cout[gi])
            );
            // Group lookahead: next slice carry from this slice's G/P only.
            assign w_carry[gi+1] = w_g[gi] | (w_p[gi] & w_carry[gi]);
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result <= WIDTH'(DATA_RESET);
            r_valid  <= 1'b0;
        end else begin
            r_valid <= bus.i_valid;
            if (bus.i_valid) begin
                r_result <= w_sum;
            end
        end
    end

    assign bus.o_result = r_result;
    assign bus.o_valid  = r_valid;

`ifdef ADDER_FLAGS_EN
    logic r_carry;
    logic r_overflow;
    logic w_unused_cout;

    // Slice-local couts duplicate the group chain; only the chain is used.
    assign w_unused_cout = ^w_cout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (bus.i_valid) begin
            r_carry    <= w_carry[NSLICE];
            r_overflow <= signed_ovf(bus.i_op1[WIDTH-1], bus.i_op2[WIDTH-1], w_sum[WIDTH-1]);
        end
    end

    assign bus.o_carry    = r_carry;
    assign bus.o_overflow = r_overflow;
`else
    logic w_unused_cout;

    assign w_unused_cout  = ^{w_cout, w_carry[NSLICE]};
    assign bus.o_carry    = 1'b0;
    assign bus.o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_adder32.sv
// Directed and random checks of adder32; expected flags are forced to 0
// when ADDER_FLAGS_EN is undefined.
module tb_adder32;

`ifdef ADDER_FLAGS_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    // Reference-model state for the random phase.
    logic [31:0] exp_res;
    logic        exp_v;
    logic        exp_c;
    logic        exp_o;

    adder32_if #(.WIDTH(32)) ifc ();

    adder32 #(.WIDTH(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b);
        rst         = r;
        ifc.i_valid = v;
        ifc.i_op1   = a;
        ifc.i_op2   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] res, input logic v,
                              input logic c, input logic o);
        $display("%s: result=0x%08h valid=%0b carry=%0b ovf=%0b", tag,
                 ifc.o_result, ifc.o_valid, ifc.o_carry, ifc.o_overflow);
        check({tag, "_res"},   64'(ifc.o_result),   64'(res));
        check({tag, "_valid"}, 64'(ifc.o_valid),    64'(v));
        check({tag, "_carry"}, 64'(ifc.o_carry),    64'(c & FL));
        check({tag, "_ovf"},   64'(ifc.o_overflow), 64'(o & FL));
    endtask

    task automatic model(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (r) begin
            exp_res = 32'h0; exp_v = 1'b0; exp_c = 1'b0; exp_o = 1'b0;
        end else begin
            exp_v = v;
            if (v) begin
                exp_res = s[31:0];
                exp_c   = s[32] & FL;
                exp_o   = (a[31] == b[31]) && (s[31] != a[31]) && FL;
            end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_total     = 0;
        n_pass      = 0;
        rst         = 1'b1;
        ifc.i_valid = 1'b0;
        ifc.i_op1   = 32'h0;
        ifc.i_op2   = 32'h0;

        // Reset held two cycles, with a valid pair present to show reset wins.
        cycle(1'b1, 1'b1, 32'd7, 32'd7);
        expect_out("reset1", 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 32'd0);
        expect_out("reset2", 32'h0, 1'b0, 1'b0, 1'b0);

        // Back-to-back stream: each result one cycle after its operands.
        cycle(1'b0, 1'b1, 32'd5, 32'd3);
        expect_out("add_5_3", 32'd8, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'd10, 32'd5);
        expect_out("add_10_5", 32'd15, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'd25, 32'd50);
        expect_out("add_25_50", 32'd75, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'd0, 32'd0);
        expect_out("add_0_0", 32'd0, 1'b1, 1'b0, 1'b0);

        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_out("wrap", 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
        expect_out("ovf_pos", 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
        expect_out("ovf_neg", 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_out("neg1_neg1", 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);

        // Hold: valid low keeps the last result and flags.
        cycle(1'b0, 1'b1, 32'd5, 32'd3);
        expect_out("hold_pre", 32'd8, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'd9, 32'd9);
        expect_out("hold", 32'd8, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
        expect_out("hold_flag_pre", 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'd1, 32'd1);
        expect_out("hold_flag", 32'h8000_0000, 1'b0, 1'b0, 1'b1);

        // Reset on the same edge as a valid pair discards it.
        cycle(1'b1, 1'b1, 32'd100, 32'd1);
        expect_out("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'd100, 32'd1);
        expect_out("after_rst", 32'd101, 1'b1, 1'b0, 1'b0);

        // Random scoreboard against a 33-bit reference sum.
        model(1'b0, 1'b1, 32'd100, 32'd1);
        for (int i = 0; i < 10000; i++) begin
            logic        r;
            logic        v;
            logic [31:0] a;
            logic [31:0] b;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            a = pick_operand();
            b = pick_operand();
            model(r, v, a, b);
            cycle(r, v, a, b);
            check("rnd_res",   64'(ifc.o_result),   64'(exp_res));
            check("rnd_valid", 64'(ifc.o_valid),    64'(exp_v));
            check("rnd_carry", 64'(ifc.o_carry),    64'(exp_c));
            check("rnd_ovf",   64'(ifc.o_overflow), 64'(exp_o));
        end
        $display("random: 10000 vectors applied");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
